tc_timer: RTL

//  Memory-mapped countdown timer device on the CPU data bus, behind the system bridge.

---
 rtl/tc_timer.sv | 91 +++++++++
 1 files changed

// File: rtl/tc_timer.sv
// tc_timer: memory-mapped countdown timer with one-shot / auto-reload modes and a maskable irq
//
// Register map (word offset addr[3:2]):
//   0x0 CTRL   [0] EN, [2:1] MODE (01 auto-reload, anything else one-shot), [3] IM
//   0x4 PRESET full 32-bit reload value
//   0x8 COUNT  current count, read-only
//   0xC        reads 0
//
// Ports:
//   clk     system clock, all state on the rising edge
//   reset   asynchronous active-low reset
//   addr    word address addr[31:2]; only addr[3:2] is decoded
//   we      write strobe, already qualified by the bridge's address range
//   byteen  per-byte write enables for din
//   din     write data
//   dout    combinational read data selected by addr[3:2]
//   irq     interrupt request = pending flag masked by CTRL.IM
module tc_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    state_t      r_state;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;
    logic        w_ctrl_wr;
    logic        w_preset_wr;
    logic        w_reload;
    logic [31:0] w_preset_nxt;
    // A CTRL write with no byte enabled changes nothing, so it neither clears
    // the pending flag nor blocks the one-shot EN clear.
    assign w_ctrl_wr   = we && addr[3:2] == 2'd0 && |byteen;
    assign w_preset_wr = we && addr[3:2] == 2'd1;
    assign w_reload    = r_ctrl[2:1] == 2'b01;
    assign w_preset_nxt = {byteen[3] ? din[31:24] : r_preset[31:24],
                           byteen[2] ? din[23:16] : r_preset[23:16],
                           byteen[1] ? din[15:8]  : r_preset[15:8],
                           byteen[0] ? din[7:0]   : r_preset[7:0]};
    assign dout = !reset             ? 32'd0 :
                  addr[3:2] == 2'd0  ? {28'd0, r_ctrl} :
                  addr[3:2] == 2'd1  ? r_preset :
                  addr[3:2] == 2'd2  ? r_count : 32'd0;
    assign irq = r_irq_flag & r_ctrl[3];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_ctrl     <= 4'd0;
            r_preset   <= 32'd0;
            r_count    <= 32'd0;
            r_irq_flag <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (r_ctrl[0]) r_state <= LOAD;
                LOAD: begin
                    r_count <= r_preset;
                    r_state <= CNT;
                end
                // Terminal step covers both 1 and 0, so PRESET=0 acts like 1 and COUNT never wraps.
                CNT: begin
                    if (!r_ctrl[0]) r_state <= IDLE;
                    else if (r_count > 32'd1) r_count <= r_count - 32'd1;
                    else begin
                        r_count    <= 32'd0;
                        r_irq_flag <= 1'b1;
                        r_state    <= INT;
                    end
                end
                INT: begin
                    r_state <= IDLE;
                    if (w_reload) r_irq_flag <= 1'b0;
                    else if (!w_ctrl_wr) r_ctrl[0] <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
            // CPU writes come last so they override FSM updates at the same edge.
            if (w_ctrl_wr) begin
                r_irq_flag <= 1'b0;
                if (byteen[0]) r_ctrl <= din[3:0];
            end
            if (w_preset_wr) r_preset <= w_preset_nxt;
        end
    end
endmodule
